psum_seq: RTL
=============

PSUM_SEQ -- requirements
Module: psum_seq

Interface
REQ-001 SHALL have parameter CNTW, default 8, width of step and pass counts.
REQ-002 SHALL have parameter SHTW, default 3, width of shift field; matches the SSctl sht_num width.
REQ-003 SHALL have i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have cfg_rdy  input  1  and cfg_ack  output  1: config handshake; transfer when both high.
REQ-006 SHALL have cfg_nstep  input  CNTW  accumulation steps per pass (0 treated as 1).
REQ-007 SHALL have cfg_npass  input  CNTW  passes per job (0 treated as 1).
REQ-008 SHALL have cfg_mode  input  psum_mode type  D16/D32, copied to every issued control word.
REQ-009 SHALL have cfg_pread  input  1  first step of each pass reads the stored partial sum instead of clearing.
REQ-010 SHALL have cfg_sht  input  SHTW  shift applied on every non-final step.
REQ-011 SHALL have o_rdy  output  1  and o_ack  input  1: control-word handshake toward the sum stage.
REQ-012 SHALL have o_ssctl  output  SSctl  control word: resetsum, psumread, sht_num, psum_mode.
REQ-013 SHALL have o_write  output  1  partial-sum writeback flag, driven into ppctl.write.
REQ-014 SHALL have o_busy  output  1  high in RUN and DONE.
REQ-015 SHALL have o_done  output  1  one-cycle job-complete pulse.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on a config transfer; RUN->DONE on the transfer of the last step of the last pass; DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL drive cfg_ack high only in IDLE, and SHALL latch all cfg_* fields on the transfer cycle.
REQ-018 SHALL raise o_rdy in the cycle after a config transfer, carrying step 0 of pass 0.
REQ-019 SHALL hold o_rdy, o_ssctl and o_write stable while o_rdy && !o_ack.
REQ-020 SHALL advance the step counter on each transfer; at step nstep-1 it SHALL wrap to 0 and increment the pass counter.
REQ-021 SHALL keep o_rdy high back-to-back in RUN, one control word per cycle when o_ack is held high.
REQ-022 SHALL set resetsum = (step==0 && !pread) and psumread = (step==0 && pread).
REQ-023 SHALL set sht_num = 0 on step nstep-1 and cfg_sht otherwise; when nstep==1, sht_num = 0.
REQ-024 SHALL set o_write = (step == nstep-1).
REQ-025 SHALL drive o_rdy low in IDLE and DONE and SHALL pulse o_done in DONE.
REQ-026 SHALL ignore cfg_rdy in DONE; a config request presented there SHALL be accepted in the following IDLE cycle.
REQ-027 SHALL compare counters at CNTW bits with no overflow; the maximum count is 2^CNTW-1.

Reset
REQ-028 On i_rst SHALL enter IDLE, clear all counters and latched config, and drive o_rdy, o_write, o_done and o_busy to 0, cfg_ack to 1 and o_ssctl to all zeros.
REQ-029 A reset mid-job SHALL abandon the job without asserting o_done; no control word is issued in the cycle following reset.

Configuration
REQ-030 With PSUM_SEQ_STALL_CNT_EN defined, SHALL add output o_stall_cnt (16 bits).
- Counts cycles with o_rdy && !o_ack.
- Saturates at 16'hFFFF.
- Cleared on reset and on each config transfer.
REQ-031 Without PSUM_SEQ_STALL_CNT_EN, the o_stall_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-032 The SSctl struct, the psum_mode enum (D16/D32) and the state enum SHALL reside in the shared PE control package; CNTW and SHTW defaults SHALL reside in the same package.
REQ-033 A single sub-module psum_seq_cnt (CNTW-bit counter with terminal-count compare and wrap) SHALL be instantiated twice, once for steps and once for passes.

Verification
REQ-034 nstep=4, npass=1, sht=1, pread=0, o_ack tied high -> four words on consecutive cycles.
- resetsum 1,0,0,0; sht 1,1,1,0; write 0,0,0,1.
- o_done pulses 1 cycle after the 4th transfer.
REQ-035 nstep=2, npass=3, pread=1, mode=D16 -> six words.
- psumread=1 on words 1, 3 and 5; write=1 on words 2, 4 and 6.
- psum_mode=D16 on all six words.
REQ-036 nstep=3, o_ack low for 5 cycles on word 2 -> word 2 held unchanged for 5 cycles; with the stall-count macro defined, o_stall_cnt=5.
REQ-037 nstep=0, npass=0 -> exactly one word with resetsum=1, sht=0, write=1, followed by o_done.
REQ-038 i_rst asserted after 2 of 4 transfers -> next cycle IDLE, cfg_ack=1, o_rdy=0, no o_done; a new config is then accepted normally.
REQ-039 cfg_rdy held high through the DONE cycle -> cfg_ack=0 in DONE; accepted in the next IDLE cycle; o_rdy rises one cycle later.

Source files
------------

// File: rtl/psum_seq_pkg.sv
// Shared PE control package: partial-sum control word, accumulation mode,
// sequencer state encoding and default counter/shift widths.
package psum_seq_pkg;

   localparam int CNTW_DEF = 8;
   localparam int SHTW_DEF = 3;

   // Accumulation data width selected for the sum stage
   typedef enum logic {
      D16 = 1'b0,
      D32 = 1'b1
   } psum_mode_e;

   // Control word handed to the sum stage for every accumulation step
   typedef struct packed {
      logic                resetsum;
      logic                psumread;
      logic [SHTW_DEF-1:0] sht_num;
      psum_mode_e          psum_mode;
   } SSctl;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/psum_seq_cnt.sv
// Wrapping CNTW-bit counter: advances on inc_i, returns to zero after
// reaching term_i, and can be cleared synchronously at the start of a job.
module psum_seq_cnt
   import psum_seq_pkg::*;
#(
   parameter int CNTW = CNTW_DEF
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   input  logic            inc_i,
   input  logic [CNTW-1:0] term_i,
   output logic [CNTW-1:0] cnt_o
);

   logic [CNTW-1:0] cnt_q;
   logic [CNTW-1:0] cnt_d;

   // Next count: clear wins, otherwise step forward and wrap at the terminal value
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = (cnt_q == term_i) ? '0 : cnt_q + CNTW'(1);
      end
   end

   // Count register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/psum_seq.sv
// Partial-sum sequencer: accepts a job configuration, then issues one SSctl
// control word per accepted handshake, nstep words per pass, npass passes.
// Optional feature macro: PSUM_SEQ_STALL_CNT_EN adds o_stall_cnt, a
// saturating count of cycles where a word was offered but not taken.
module psum_seq
   import psum_seq_pkg::*;
#(
   parameter int CNTW = CNTW_DEF,
   parameter int SHTW = SHTW_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            cfg_rdy,
   output logic            cfg_ack,
   input  logic [CNTW-1:0] cfg_nstep,
   input  logic [CNTW-1:0] cfg_npass,
   input  psum_mode_e      cfg_mode,
   input  logic            cfg_pread,
   input  logic [SHTW-1:0] cfg_sht,
   output logic            o_rdy,
   input  logic            o_ack,
   output SSctl            o_ssctl,
   output logic            o_write,
   output logic            o_busy,
   output logic            o_done
`ifdef PSUM_SEQ_STALL_CNT_EN
   ,
   output logic [15:0]     o_stall_cnt
`endif
);

   state_e          state_q;
   state_e          state_d;

   logic [CNTW-1:0] stepTerm_q;
   logic [CNTW-1:0] passTerm_q;
   psum_mode_e      mode_q;
   logic            pread_q;
   logic [SHTW-1:0] sht_q;

   logic [CNTW-1:0] stepCnt;
   logic [CNTW-1:0] passCnt;
   logic            cfgXfer;
   logic            outXfer;
   logic            stepFirst;
   logic            stepTc;
   logic            passTc;

   // A count of zero means a single step/pass, so the terminal value is n-1 clamped at 0
   function automatic logic [CNTW-1:0] termOf(input logic [CNTW-1:0] n);
      return (n == '0) ? '0 : n - CNTW'(1);
   endfunction

   assign cfgXfer   = cfg_rdy && cfg_ack;
   assign outXfer   = o_rdy && o_ack;
   assign stepFirst = (stepCnt == '0);
   assign stepTc    = (stepCnt == stepTerm_q);
   assign passTc    = (passCnt == passTerm_q);

   // Capture the job configuration on the accepting handshake
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stepTerm_q <= '0;
         passTerm_q <= '0;
         mode_q     <= D16;
         pread_q    <= 1'b0;
         sht_q      <= '0;
      end else if (cfgXfer) begin
         stepTerm_q <= termOf(cfg_nstep);
         passTerm_q <= termOf(cfg_npass);
         mode_q     <= cfg_mode;
         pread_q    <= cfg_pread;
         sht_q      <= cfg_sht;
      end
   end

   psum_seq_cnt #(.CNTW(CNTW)) uStepCnt (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .clr_i  (cfgXfer),
      .inc_i  (outXfer),
      .term_i (stepTerm_q),
      .cnt_o  (stepCnt)
   );

   psum_seq_cnt #(.CNTW(CNTW)) uPassCnt (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .clr_i  (cfgXfer),
      .inc_i  (outXfer && stepTc),
      .term_i (passTerm_q),
      .cnt_o  (passCnt)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and outputs; the control word is only driven while RUN offers it
   always_comb begin
      state_d = state_q;
      cfg_ack = 1'b0;
      o_rdy   = 1'b0;
      o_write = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      o_ssctl = '0;
      case (state_q)
         IDLE: begin
            cfg_ack = 1'b1;
            if (cfg_rdy) begin
               state_d = RUN;
            end
         end
         RUN: begin
            o_rdy             = 1'b1;
            o_busy            = 1'b1;
            o_write           = stepTc;
            o_ssctl.resetsum  = stepFirst && !pread_q;
            o_ssctl.psumread  = stepFirst && pread_q;
            o_ssctl.sht_num   = stepTc ? '0 : sht_q;
            o_ssctl.psum_mode = mode_q;
            if (o_ack && stepTc && passTc) begin
               state_d = DONE;
            end
         end
         DONE: begin
            o_busy  = 1'b1;
            o_done  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef PSUM_SEQ_STALL_CNT_EN
   logic [15:0] stallCnt_q;

   // Saturating count of back-pressured cycles, restarted for every job
   always_ff @(posedge i_clk) begin
      if (i_rst || cfgXfer) begin
         stallCnt_q <= '0;
      end else if (o_rdy && !o_ack && (stallCnt_q != 16'hFFFF)) begin
         stallCnt_q <= stallCnt_q + 16'd1;
      end
   end

   assign o_stall_cnt = stallCnt_q;
`endif

endmodule
